// File: rtl/acc_pkg.sv
// Shared types for the multi-channel accumulator.
// The request struct is declared in acc_array because its field widths follow the module parameters.
package acc_pkg;

    typedef enum logic [1:0] {
        ACC_ADD  = 2'd0,
        ACC_SUB  = 2'd1,
        ACC_LOAD = 2'd2,
        ACC_READ = 2'd3
    } acc_op_e;

endpackage

// File: rtl/acc_array_if.sv
// Request/result handshake bundle between producer, accumulator array and consumer.
// The master side drives requests and accepts results; the slave side is the array.
interface acc_array_if
    import acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
) ();

    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch;
    acc_op_e          in_op;
    logic [WIDTH-1:0] in_x;

    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [WIDTH-1:0] out_q;
    logic             out_ovf;

    modport master (
        output in_valid, in_ch, in_op, in_x, out_ready,
        input  in_ready, out_valid, out_ch, out_q, out_ovf
    );

    modport slave (
        input  in_valid, in_ch, in_op, in_x, out_ready,
        output in_ready, out_valid, out_ch, out_q, out_ovf
    );

endinterface

// File: rtl/acc_alu.sv
// Accumulator ALU: add/sub with carry-out as overflow, load, read; optional clamping.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module acc_alu
    import acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] x,
    input  acc_op_e          op,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, x};
        diff = {1'b0, acc} - {1'b0, x};
        r    = acc;
        ovf  = 1'b0;
        unique case (op)
            ACC_ADD: begin
                ovf = sum[WIDTH];
                r   = (SAT && ovf) ? '1 : sum[WIDTH-1:0];
            end
            ACC_SUB: begin
                // The extra bit of the difference is the borrow.
                ovf = diff[WIDTH];
                r   = (SAT && ovf) ? '0 : diff[WIDTH-1:0];
            end
            ACC_LOAD: r = x;
            ACC_READ: r = acc;
        endcase
    end

endmodule

// File: rtl/acc_array.sv
// NCH-channel accumulator: one request per cycle, result two edges after acceptance.
// Latency: 2 cycles (S1 register, then compute + write + output register).
// Backpressure: S1 and the channel write advance only when the output slot is free or taken.
module acc_array
    import acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter bit SAT   = 1'b0,
    parameter int CH_W  = $clog2(NCH > 1 ? NCH : 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_all,
    acc_array_if.slave      bus,
    output logic [NCH-1:0]  ovf_sticky
);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        acc_op_e          op;
        logic [WIDTH-1:0] x;
    } acc_req_t;

    acc_req_t         s1_req;
    logic             s1_valid;
    logic [WIDTH-1:0] acc_q [NCH];

    logic             advance;
    logic             s1_hit;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ovf;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !clr_all && (!s1_valid || advance);
    // Out-of-range channels flow through S1 but never touch state or the output.
    assign s1_hit       = s1_valid && (32'(s1_req.ch) < NCH);

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s1_req.ch == CH_W'(i)) rd_val = acc_q[i];
        end
    end

    acc_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .acc (rd_val),
        .x   (s1_req.x),
        .op  (s1_req.op),
        .r   (alu_r),
        .ovf (alu_ovf)
    );

    // The channel write lands on the same edge S1 drains, so a following
    // request to the same channel reads the fresh value without forwarding.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_all) begin
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
            ovf_sticky    <= '0;
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            if (!rst_n) begin
                bus.out_ch  <= '0;
                bus.out_q   <= '0;
                bus.out_ovf <= 1'b0;
            end
        end else begin
            if (advance) begin
                bus.out_valid <= s1_hit;
                if (s1_hit) begin
                    bus.out_ch             <= s1_req.ch;
                    bus.out_q              <= alu_r;
                    bus.out_ovf            <= alu_ovf;
                    acc_q[s1_req.ch]       <= alu_r;
                    ovf_sticky[s1_req.ch]  <= ovf_sticky[s1_req.ch] | alu_ovf;
                end
            end
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                s1_req   <= '{ch: bus.in_ch, op: bus.in_op, x: bus.in_x};
            end
        end
    end

endmodule
